// File: rtl/ale_top.sv
`default_nettype none
// =============================================================================
// ale_top : atmospheric light estimation, brightest dark-channel pixel per frame
// Revision: 1.0
// =============================================================================
module ale_top #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] input_pixel,
    input  logic        input_is_valid,
    output logic [7:0]  a_r,
    output logic [7:0]  a_g,
    output logic [7:0]  a_b,
    output logic [15:0] inv_a_r,
    output logic [15:0] inv_a_g,
    output logic [15:0] inv_a_b,
    output logic        ale_valid
);
    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [15:0] recip_rom [256];

    // floor(65536/x) with 0 and 1 saturated to full scale
    for (genvar gi = 0; gi < 256; gi++) begin : g_recip
        if (gi < 2) begin : g_sat
            assign recip_rom[gi] = 16'hFFFF;
        end else begin : g_div
            assign recip_rom[gi] = 16'(65536 / gi);
        end
    end

    logic [CW-1:0] cnt_d, cnt_q;
    logic          s1_valid_d, s1_valid_q;
    logic [23:0]   s1_pix_d, s1_pix_q;
    logic [7:0]    s1_dark_d, s1_dark_q;
    logic          s1_first_d, s1_first_q;
    logic          s1_last_d, s1_last_q;
    logic [7:0]    max_d, max_q;
    logic [23:0]   best_d, best_q;
    logic          s2_done_d, s2_done_q;
    logic [23:0]   snap_d, snap_q;
    logic          snap_valid_d, snap_valid_q;
    logic [23:0]   a_d, a_q;
    logic [15:0]   inv_r_d, inv_r_q, inv_g_d, inv_g_q, inv_b_d, inv_b_q;
    logic          ale_valid_d, ale_valid_q;
    logic [7:0]    min_rg;

    always_comb begin
        cnt_d = cnt_q;
        if (input_is_valid) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end

        min_rg     = (input_pixel[23:16] < input_pixel[15:8]) ? input_pixel[23:16] : input_pixel[15:8];
        s1_dark_d  = (min_rg < input_pixel[7:0]) ? min_rg : input_pixel[7:0];
        s1_valid_d = input_is_valid;
        s1_pix_d   = input_pixel;
        s1_first_d = (cnt_q == '0);
        s1_last_d  = (cnt_q == LAST_IDX);

        // Strict compare so ties keep the earliest pixel of the frame
        max_d  = max_q;
        best_d = best_q;
        if (s1_valid_q && (s1_first_q || (s1_dark_q > max_q))) begin
            max_d  = s1_dark_q;
            best_d = s1_pix_q;
        end
        s2_done_d = s1_valid_q && s1_last_q;

        // Snapshot frees best_q for an immediately following frame
        snap_valid_d = s2_done_q;
        snap_d       = s2_done_q ? best_q : snap_q;

        ale_valid_d = snap_valid_q;
        a_d         = a_q;
        inv_r_d     = inv_r_q;
        inv_g_d     = inv_g_q;
        inv_b_d     = inv_b_q;
        if (snap_valid_q) begin
            a_d     = snap_q;
            inv_r_d = recip_rom[snap_q[23:16]];
            inv_g_d = recip_rom[snap_q[15:8]];
            inv_b_d = recip_rom[snap_q[7:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            s1_dark_q    <= '0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            max_q        <= '0;
            best_q       <= '0;
            s2_done_q    <= 1'b0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            a_q          <= '0;
            inv_r_q      <= '0;
            inv_g_q      <= '0;
            inv_b_q      <= '0;
            ale_valid_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_pix_q     <= s1_pix_d;
            s1_dark_q    <= s1_dark_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            max_q        <= max_d;
            best_q       <= best_d;
            s2_done_q    <= s2_done_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            a_q          <= a_d;
            inv_r_q      <= inv_r_d;
            inv_g_q      <= inv_g_d;
            inv_b_q      <= inv_b_d;
            ale_valid_q  <= ale_valid_d;
        end
    end

    assign a_r       = a_q[23:16];
    assign a_g       = a_q[15:8];
    assign a_b       = a_q[7:0];
    assign inv_a_r   = inv_r_q;
    assign inv_a_g   = inv_g_q;
    assign inv_a_b   = inv_b_q;
    assign ale_valid = ale_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ale_top.sv
`default_nettype none
// =============================================================================
// tb_ale_top : scoreboard bench for ale_top on a 2x2 and a 16x16 instance
// Revision: 1.0
// =============================================================================
module tb_ale_top;
    typedef struct {
        logic [7:0]  r, g, b;
        logic [15:0] ir, ig, ib;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] s_pix = '0, m_pix = '0;
    logic        s_vld = 1'b0, m_vld = 1'b0;
    logic [7:0]  s_ar, s_ag, s_ab, m_ar, m_ag, m_ab;
    logic [15:0] s_ir, s_ig, s_ib, m_ir, m_ig, m_ib;
    logic        s_av, m_av;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t q_s[$];
    exp_t q_m[$];
    exp_t last_s = '{8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 0};
    exp_t es, em;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ale_top #(.IMG_WIDTH(2), .IMG_HEIGHT(2)) u_small (
        .clk(clk), .rst(rst), .input_pixel(s_pix), .input_is_valid(s_vld),
        .a_r(s_ar), .a_g(s_ag), .a_b(s_ab),
        .inv_a_r(s_ir), .inv_a_g(s_ig), .inv_a_b(s_ib), .ale_valid(s_av)
    );

    ale_top #(.IMG_WIDTH(16), .IMG_HEIGHT(16)) u_mid (
        .clk(clk), .rst(rst), .input_pixel(m_pix), .input_is_valid(m_vld),
        .a_r(m_ar), .a_g(m_ag), .a_b(m_ab),
        .inv_a_r(m_ir), .inv_a_g(m_ig), .inv_a_b(m_ib), .ale_valid(m_av)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] recip(input logic [7:0] x);
        if (x < 8'd2) return 16'hFFFF;
        return 16'(65536 / int'(x));
    endfunction

    function automatic logic [7:0] dark(input logic [23:0] p);
        logic [7:0] m;
        m = (p[23:16] < p[15:8]) ? p[23:16] : p[15:8];
        return (m < p[7:0]) ? m : p[7:0];
    endfunction

    always @(negedge clk) begin
        if (s_av) begin
            chk("s_pulse_expected", 32'(q_s.size() != 0), 32'd1);
            if (q_s.size() != 0) begin
                es = q_s.pop_front();
                chk("s_latency", cyc, es.cyc);
                chk("s_a_r", s_ar, es.r);
                chk("s_a_g", s_ag, es.g);
                chk("s_a_b", s_ab, es.b);
                chk("s_inv_r", s_ir, es.ir);
                chk("s_inv_g", s_ig, es.ig);
                chk("s_inv_b", s_ib, es.ib);
                last_s = es;
            end
        end
        if (m_av) begin
            chk("m_pulse_expected", 32'(q_m.size() != 0), 32'd1);
            if (q_m.size() != 0) begin
                em = q_m.pop_front();
                chk("m_latency", cyc, em.cyc);
                chk("m_a_r", m_ar, em.r);
                chk("m_a_g", m_ag, em.g);
                chk("m_a_b", m_ab, em.b);
                chk("m_inv_r", m_ir, em.ir);
                chk("m_inv_g", m_ig, em.ig);
                chk("m_inv_b", m_ib, em.ib);
            end
        end
    end

    task automatic drv_s(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        s_pix = {r, g, b};
        s_vld = 1'b1;
    endtask

    task automatic idle_s(input int n);
        repeat (n) begin
            @(negedge clk);
            s_vld = 1'b0;
        end
    endtask

    // Called right after the frame's last pixel is driven: pulse seen 3 edges after acceptance
    task automatic exp_s(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [15:0] ir, input logic [15:0] ig, input logic [15:0] ib);
        q_s.push_back('{r, g, b, ir, ig, ib, cyc + 4});
    endtask

    task automatic hold_s(input string tag);
        chk({tag, "_a_r"}, s_ar, last_s.r);
        chk({tag, "_a_g"}, s_ag, last_s.g);
        chk({tag, "_a_b"}, s_ab, last_s.b);
        chk({tag, "_inv_r"}, s_ir, last_s.ir);
        chk({tag, "_inv_g"}, s_ig, last_s.ig);
        chk({tag, "_inv_b"}, s_ib, last_s.ib);
        chk({tag, "_valid"}, s_av, 1'b0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        last_s = '{8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 0};
        hold_s("rst_async");
        chk("rst_async_m_a", {8'd0, m_ar, m_ag, m_ab}, 32'd0);
        chk("rst_async_m_inv", {m_ir, m_ig}, 32'd0);
        @(negedge clk);
        s_vld = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] p;
        logic [23:0] best;
        logic [7:0]  bmax;

        repeat (2) @(negedge clk);
        hold_s("reset");
        chk("reset_m_a", {8'd0, m_ar, m_ag, m_ab}, 32'd0);
        chk("reset_m_inv", {m_ir, m_ib}, 32'd0);
        chk("reset_m_valid", m_av, 1'b0);
        rst = 1'b0;
        idle_s(2);

        // Max selection
        drv_s(200, 250, 210); drv_s(255, 10, 255); drv_s(90, 90, 90); drv_s(180, 190, 220);
        exp_s(200, 250, 210, 327, 262, 312);
        idle_s(8);
        hold_s("hold1");

        // Tie break keeps the earlier pixel
        drv_s(10, 20, 30); drv_s(100, 120, 140); drv_s(50, 60, 70); drv_s(150, 100, 200);
        exp_s(100, 120, 140, 655, 546, 468);
        idle_s(6);

        // Reciprocal edges, first pixel loads with dark 0
        drv_s(0, 1, 255); drv_s(0, 0, 0); drv_s(5, 0, 9); drv_s(0, 200, 3);
        exp_s(0, 1, 255, 65535, 65535, 257);
        idle_s(6);
        hold_s("hold2");

        // Gaps, then a back-to-back frame
        drv_s(10, 10, 10); idle_s(1); drv_s(30, 40, 50); idle_s(2); drv_s(20, 20, 20); drv_s(1, 2, 3);
        exp_s(30, 40, 50, 2184, 1638, 1310);
        drv_s(5, 6, 7); drv_s(5, 6, 7); drv_s(5, 6, 7); drv_s(5, 6, 7);
        exp_s(5, 6, 7, 13107, 10922, 9362);
        idle_s(8);
        hold_s("hold3");

        // Partial frame then asynchronous reset
        drv_s(250, 250, 250); drv_s(1, 1, 1); drv_s(2, 2, 2);
        async_reset();
        drv_s(240, 240, 240); drv_s(241, 241, 241); drv_s(242, 242, 242);
        idle_s(8);
        hold_s("partial");
        async_reset();

        // Fresh frame after the discarded partials
        drv_s(77, 88, 99); drv_s(1, 1, 1); drv_s(2, 2, 2); drv_s(3, 3, 3);
        exp_s(77, 88, 99, 851, 744, 661);
        idle_s(8);

        // Two back-to-back 16x16 frames against a first-occurrence argmax model
        for (int f = 0; f < 2; f++) begin
            bmax = '0;
            best = '0;
            for (int i = 0; i < 256; i++) begin
                if (f == 0 && $urandom_range(0, 7) == 0) begin
                    @(negedge clk);
                    m_vld = 1'b0;
                end
                p = {8'($urandom_range(60, 160)), 8'($urandom_range(60, 160)), 8'($urandom_range(60, 160))};
                if (i == 0 || dark(p) > bmax) begin
                    bmax = dark(p);
                    best = p;
                end
                @(negedge clk);
                m_pix = p;
                m_vld = 1'b1;
            end
            q_m.push_back('{best[23:16], best[15:8], best[7:0],
                            recip(best[23:16]), recip(best[15:8]), recip(best[7:0]), cyc + 4});
        end
        @(negedge clk);
        m_vld = 1'b0;

        for (int i = 0; i < 20 && (q_s.size() + q_m.size()) != 0; i++) @(negedge clk);
        chk("queue_drained", q_s.size() + q_m.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ale_top.md
Name: ale_top

Overview:
- Atmospheric Light Estimation (ALE) block of the image haze-removal pipeline.
- Consumes one 24-bit RGB pixel per valid cycle for a full frame.
- Selects as atmospheric light A the pixel with the brightest dark channel, where dark channel = min(R,G,B) per pixel.
- After the frame ends, outputs A per channel and a 16-bit reciprocal per channel for use by the downstream transmission and recovery stages.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, lines per frame. Frame length N = IMG_WIDTH*IMG_HEIGHT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- input_pixel  input  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B.
- input_is_valid  input  1  input_pixel is accepted on this rising edge when high.
- a_r  output  8  atmospheric light, red channel.
- a_g  output  8  atmospheric light, green channel.
- a_b  output  8  atmospheric light, blue channel.
- inv_a_r  output  16  reciprocal of a_r.
- inv_a_g  output  16  reciprocal of a_g.
- inv_a_b  output  16  reciprocal of a_b.
- ale_valid  output  1  one-cycle pulse; all six outputs are updated and valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset: a_r/a_g/a_b=0, inv_a_*=0, ale_valid=0, pixel counter=0, running max dark=0, running A=0. Reset mid-frame discards the partial frame.
- No backpressure. A pixel is accepted on every rising edge where input_is_valid=1. Gaps (valid=0) are allowed anywhere and do not advance the counter.
- Stage 1, registered: accepted pixel, dark = min(R,G,B), last flag (counter == N-1).
- Stage 2, running-max update:
  - First pixel of a frame unconditionally loads max=dark and A=pixel.
  - Afterwards, if dark > max (strict), load max=dark and A=pixel.
  - Ties keep the earlier pixel.
- Stage 3: on the last pixel, register a_* = A (including the last pixel's update) and inv_a_* from a 256-entry reciprocal function.
  - inv(x) = floor(65536/x) saturated to 65535.
  - inv(0) = 65535, inv(1) = 65535.
- Latency: ale_valid is high for exactly one cycle. It is registered high by the 3rd rising edge after the edge that accepted the last pixel of the frame.
- Outputs hold their values between pulses. They change only at an ale_valid update or at reset.
- Pixel counter wraps to 0 after N accepted pixels. The next frame starts immediately, with its running max reset, so back-to-back frames with no gap are supported. Stage 3 of frame k and stage 1 of frame k+1 overlap without interference.
- Only a complete frame of N accepted pixels produces ale_valid. Trailing partial frames produce nothing.
- Width rules:
  - dark and max are 8-bit unsigned.
  - The counter is ceil(log2(N)) bits wide, minimum 1.
  - Reciprocal is 16-bit unsigned integer (Q0.16 scale of 1/x).

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately. Release, then stream 3 valid pixels of a 2x2 frame -> no ale_valid.
- Max selection (IMG_WIDTH=2, IMG_HEIGHT=2): pixels (R,G,B) = (200,250,210), (255,10,255), (90,90,90), (180,190,220) -> A=(200,250,210). inv_a_r=327, inv_a_g=262, inv_a_b=312. Single ale_valid pulse 3 edges after the 4th pixel.
- Tie break: 2x2 frame with dark=100 at pixels 1 and 3, pixel 1=(100,120,140), pixel 3=(150,100,200) -> A=(100,120,140). inv=655,546,468.
- Reciprocal edges: frame whose max pixel is (0,1,255) with all others dark 0 -> first pixel loads, ties keep it. A=(0,1,255), inv=65535,65535,257.
- Valid gaps and back-to-back frames: 2x2 frames with idle cycles inserted, followed by a second frame with no gap -> two ale_valid pulses. The second frame's A is independent of the first (e.g. all pixels (5,6,7) -> A=(5,6,7), inv=13107,10922,9362). Outputs hold between pulses.
- Full-size default 512x512 frame -> exactly one ale_valid pulse. Its A matches a software dark-channel argmax that uses first-occurrence tie-breaking.
